// File: rtl/branch_resolve_unit.sv
// EX-stage resolution of beq branches: compares operands, flushes on misprediction,
// trains a 2-bit saturating predictor and keeps saturating branch/mispredict counts.
`timescale 1ns/1ps
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Branch_i,
  input  logic              Predict_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [DATA_W-1:0] PC_i,
  output logic              Predict_o,
  output logic              Flush_o,
  output logic [DATA_W-1:0] RedirectPC_o,
  output logic [CNT_W-1:0]  BranchCnt_o,
  output logic [CNT_W-1:0]  MispredCnt_o
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic                     taken;
  logic signed [DATA_W-1:0] imm_s;
  logic        [DATA_W-1:0] target;
  logic        [DATA_W-1:0] fall_thru;
  logic        [CNT_W-1:0]  br_cnt_q;
  logic        [CNT_W-1:0]  mis_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Resolution is purely combinational so the flush lands in the same EX cycle.
  assign imm_s        = Imm_i;
  assign taken        = (RS1data_i == RS2data_i);
  assign target       = PC_i + $unsigned(imm_s <<< 1);
  assign fall_thru    = PC_i + DATA_W'(4);
  assign Flush_o      = Branch_i & (taken ^ Predict_i);
  assign RedirectPC_o = taken ? target : fall_thru;
  assign Predict_o    = state_q[1];
  assign BranchCnt_o  = br_cnt_q;
  assign MispredCnt_o = mis_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Branch_i) begin
      case (state_q)
        SNT:     state_d = taken ? WNT : SNT;
        WNT:     state_d = taken ? WT  : SNT;
        WT:      state_d = taken ? ST  : WNT;
        ST:      state_d = taken ? ST  : WT;
        default: state_d = ST;
      endcase
    end
  end

  // Counter updates are independent of each other and of the predictor.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (Branch_i) br_cnt_q  <= sat_inc(br_cnt_q);
      if (Flush_o)  mis_cnt_q <= sat_inc(mis_cnt_q);
    end
  end

endmodule
